// File: rtl/core_pkg.sv
// Shared constants for the core: sequencer FSM encoding, branch condition codes
// and the default reset vector.
package core_pkg;

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_unit.sv
// Resolves a conditional branch from the ALU flags; less already reflects the
// signed/unsigned flavour chosen by funct3.
module branch_unit
    import core_pkg::*;
(
    input  logic       branch,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       less,
    output logic       pc_src
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            BEQ:        cond = zero;
            BNE:        cond = ~zero;
            BLT, BLTU:  cond = less;
            BGE, BGEU:  cond = ~less;
            default:    cond = 1'b0;
        endcase
    end

    assign pc_src = branch & cond;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: next-PC arbitration, imem wait states,
// stall, misaligned-target halt and a saturating taken-redirect counter.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             less,
    input  logic             jump,
    input  logic             jalr,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [XLEN-1:0]  jalr_target,
    input  logic             stall,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             instr_commit,
    output logic             redirect,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]      state;
    logic            pc_src;
    logic            active;
    logic            commit;
    logic            redirect_sel;
    logic            misalign;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;

    branch_unit u_branch_unit (
        .branch (branch),
        .funct3 (funct3),
        .zero   (zero),
        .less   (less),
        .pc_src (pc_src)
    );

    assign active       = (state == RUN) || (state == WAIT);
    assign pc_plus4     = pc + XLEN'(4);
    assign imem_req     = active;
    assign imem_addr    = pc;
    assign commit       = active & imem_ready & ~stall;
    assign instr_commit = commit;

    // JALR outranks JAL, which outranks a resolved conditional branch.
    always_comb begin
        target       = branch_target;
        redirect_sel = 1'b0;
        if (jalr) begin
            target       = jalr_target & ~XLEN'(1);
            redirect_sel = 1'b1;
        end else if (jump) begin
            redirect_sel = 1'b1;
        end else if (pc_src) begin
            redirect_sel = 1'b1;
        end
    end

    assign next_pc  = redirect_sel ? target : pc_plus4;
    assign redirect = active & redirect_sel;
    assign misalign = commit & redirect_sel & target[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
            taken_cnt    <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, WAIT: begin
                    if (commit) begin
                        // A misaligned redirect still retires but freezes the PC.
                        if (misalign) begin
                            misalign_err <= 1'b1;
                            state        <= HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= RUN;
                            if (redirect_sel && taken_cnt != CNT_MAX)
                                taken_cnt <= taken_cnt + CNT_W'(1);
                        end
                    end else if (!imem_ready) begin
                        state <= WAIT;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected PCs are queued as stimulus is
// driven and popped when the sequencer updates.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic [2:0]  funct3;
    logic        zero;
    logic        less;
    logic        jump;
    logic        jalr;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        stall;
    logic        imem_ready;

    logic        imem_req, instr_commit, redirect, misalign_err;
    logic [31:0] imem_addr, pc, pc_plus4;
    logic [15:0] taken_cnt;

    logic        s_req, s_commit, s_redirect, s_err;
    logic [31:0] s_addr, s_pc, s_plus4;
    logic [1:0]  s_cnt;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .funct3(funct3), .zero(zero),
        .less(less), .jump(jump), .jalr(jalr), .branch_target(branch_target),
        .jalr_target(jalr_target), .stall(stall), .imem_ready(imem_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4),
        .instr_commit(instr_commit), .redirect(redirect),
        .misalign_err(misalign_err), .taken_cnt(taken_cnt)
    );

    pc_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .branch(branch), .funct3(funct3), .zero(zero),
        .less(less), .jump(jump), .jalr(jalr), .branch_target(branch_target),
        .jalr_target(jalr_target), .stall(stall), .imem_ready(imem_ready),
        .imem_req(s_req), .imem_addr(s_addr), .pc(s_pc), .pc_plus4(s_plus4),
        .instr_commit(s_commit), .redirect(s_redirect),
        .misalign_err(s_err), .taken_cnt(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        branch = 0; funct3 = 3'b000; zero = 0; less = 0; jump = 0; jalr = 0;
        branch_target = 32'h0; jalr_target = 32'h0; stall = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; clr(); imem_ready = 0;
        repeat (3) tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
        checks++; if ({imem_req, instr_commit, redirect, misalign_err} !== 4'b0) begin failures++;
            $display("FAIL reset_ctl got=%b want=0000", {imem_req, instr_commit, redirect, misalign_err}); end
        checks++; if (taken_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", taken_cnt); end
        rst_n = 1; imem_ready = 1; jump = 1; branch_target = 32'h40;
        #1;
        checks++; if ({imem_req, instr_commit, redirect} !== 3'b000) begin failures++;
            $display("FAIL boot_idle got=%b want=000", {imem_req, instr_commit, redirect}); end
        tick(); jump = 0;
        checks++; if (pc !== 32'h0 || imem_req !== 1'b1) begin failures++;
            $display("FAIL boot_to_run pc=%h req=%b want pc=0 req=1", pc, imem_req); end
        exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        repeat (3) begin
            tick(); e = exp_q.pop_front();
            checks++; if (pc !== e) begin failures++; $display("FAIL seq_pc got=%h want=%h", pc, e); end
        end
        checks++; if (taken_cnt !== 16'd0) begin failures++; $display("FAIL seq_cnt got=%0d want=0", taken_cnt); end
    endtask

    task automatic test_branch;
        exp_q.push_back(32'h10); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e) begin failures++; $display("FAIL seq_to_10 got=%h want=%h", pc, e); end
        branch = 1; funct3 = 3'b000; zero = 1; branch_target = 32'h40; #1;
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL beq_redirect got=%b want=1", redirect); end
        exp_q.push_back(32'h40); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || taken_cnt !== 16'd1) begin failures++;
            $display("FAIL beq_taken pc=%h cnt=%0d want pc=%h cnt=1", pc, taken_cnt, e); end
        funct3 = 3'b001; #1;
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL bne_redirect got=%b want=0", redirect); end
        exp_q.push_back(32'h44); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || taken_cnt !== 16'd1) begin failures++;
            $display("FAIL bne_nottaken pc=%h cnt=%0d want pc=%h cnt=1", pc, taken_cnt, e); end
        funct3 = 3'b100; less = 1; zero = 0; branch_target = 32'h60;
        exp_q.push_back(32'h60); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || taken_cnt !== 16'd2) begin failures++;
            $display("FAIL blt_taken pc=%h cnt=%0d want pc=%h cnt=2", pc, taken_cnt, e); end
        funct3 = 3'b111; branch_target = 32'h300;
        exp_q.push_back(32'h64); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e) begin failures++; $display("FAIL bgeu_nottaken got=%h want=%h", pc, e); end
        clr();
    endtask

    task automatic test_priority;
        jalr = 1; jump = 1; branch = 1; funct3 = 3'b000; zero = 1;
        jalr_target = 32'h81; branch_target = 32'h200;
        exp_q.push_back(32'h80); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || taken_cnt !== 16'd3) begin failures++;
            $display("FAIL jalr_priority pc=%h cnt=%0d want pc=%h cnt=3", pc, taken_cnt, e); end
        clr(); jump = 1; branch = 1; funct3 = 3'b001; zero = 1; branch_target = 32'h100;
        exp_q.push_back(32'h100); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || taken_cnt !== 16'd4) begin failures++;
            $display("FAIL jal_over_branch pc=%h cnt=%0d want pc=%h cnt=4", pc, taken_cnt, e); end
        clr();
    endtask

    task automatic test_wait_stall;
        jump = 1; branch_target = 32'h20;
        exp_q.push_back(32'h20); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e) begin failures++; $display("FAIL jump_to_20 got=%h want=%h", pc, e); end
        branch_target = 32'h300; imem_ready = 0; #1;
        checks++; if (redirect !== 1'b1 || instr_commit !== 1'b0) begin failures++;
            $display("FAIL wait_redirect redirect=%b commit=%b want 1 0", redirect, instr_commit); end
        jump = 0;
        repeat (4) begin
            exp_q.push_back(32'h20); tick(); e = exp_q.pop_front();
            checks++; if (pc !== e || instr_commit !== 1'b0 || imem_req !== 1'b1) begin failures++;
                $display("FAIL wait_hold pc=%h commit=%b req=%b want pc=%h commit=0 req=1", pc, instr_commit, imem_req, e); end
        end
        imem_ready = 1; stall = 1;
        repeat (2) begin
            exp_q.push_back(32'h20); tick(); e = exp_q.pop_front();
            checks++; if (pc !== e || instr_commit !== 1'b0) begin failures++;
                $display("FAIL stall_hold pc=%h commit=%b want pc=%h commit=0", pc, instr_commit, e); end
        end
        stall = 0;
        exp_q.push_back(32'h24); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || taken_cnt !== 16'd5) begin failures++;
            $display("FAIL stall_release pc=%h cnt=%0d want pc=%h cnt=5", pc, taken_cnt, e); end
    endtask

    task automatic test_wrap;
        jump = 1; branch_target = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || pc_plus4 !== 32'h0) begin failures++;
            $display("FAIL wrap_top pc=%h plus4=%h want pc=%h plus4=0", pc, pc_plus4, e); end
        jump = 0;
        exp_q.push_back(32'h0); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || misalign_err !== 1'b0 || taken_cnt !== 16'd6) begin failures++;
            $display("FAIL wrap_seq pc=%h err=%b cnt=%0d want pc=%h err=0 cnt=6", pc, misalign_err, taken_cnt, e); end
    endtask

    task automatic test_misalign;
        jump = 1; branch_target = 32'h102; #1;
        checks++; if (instr_commit !== 1'b1 || redirect !== 1'b1) begin failures++;
            $display("FAIL misalign_commit commit=%b redirect=%b want 1 1", instr_commit, redirect); end
        exp_q.push_back(32'h0); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || misalign_err !== 1'b1 || taken_cnt !== 16'd6) begin failures++;
            $display("FAIL misalign_halt pc=%h err=%b cnt=%0d want pc=%h err=1 cnt=6", pc, misalign_err, taken_cnt, e); end
        branch_target = 32'h40; #1;
        checks++; if ({imem_req, instr_commit, redirect} !== 3'b000) begin failures++;
            $display("FAIL halt_ctl got=%b want=000", {imem_req, instr_commit, redirect}); end
        exp_q.push_back(32'h0); tick(); e = exp_q.pop_front();
        checks++; if (pc !== e || misalign_err !== 1'b1) begin failures++;
            $display("FAIL halt_frozen pc=%h err=%b want pc=%h err=1", pc, misalign_err, e); end
        #2 rst_n = 0; #1;
        checks++; if (misalign_err !== 1'b0 || taken_cnt !== 16'd0 || imem_req !== 1'b0 || pc !== 32'h0) begin failures++;
            $display("FAIL async_reset err=%b cnt=%0d req=%b pc=%h want 0 0 0 0", misalign_err, taken_cnt, imem_req, pc); end
        clr(); tick(); rst_n = 1;
        tick();
    endtask

    task automatic test_saturation;
        branch = 1; funct3 = 3'b000; zero = 1;
        for (int k = 1; k <= 5; k++) begin
            branch_target = 32'(k) * 32'h40;
            exp_q.push_back(32'(k) * 32'h40); tick(); e = exp_q.pop_front();
            checks++; if (pc !== e || taken_cnt !== 16'(k)) begin failures++;
                $display("FAIL sat_wide pc=%h cnt=%0d want pc=%h cnt=%0d", pc, taken_cnt, e, k); end
            checks++; if (s_cnt !== ((k > 3) ? 2'd3 : 2'(k))) begin failures++;
                $display("FAIL sat_narrow got=%0d want=%0d", s_cnt, (k > 3) ? 3 : k); end
        end
        clr();
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_branch();
        test_priority();
        test_wait_stall();
        test_wrap();
        test_misalign();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
